z80_bus_responder: RTL and testbench
====================================

Name: z80_bus_responder

Overview:
Bus-side responder for the Z80 core. It decodes M1/MREQ/IORQ/RD/WR/RFSH strobes from the CPU and converts memory and I/O cycles into single-request/ack transactions on separate memory and I/O back-end ports. It stretches each cycle with WAIT_n until the back end acknowledges, and returns read data on the CPU data-in bus. It also generates the maskable interrupt line and answers interrupt-acknowledge cycles with an IM2 vector.

Parameters:
INT_LEN, 32, number of cpu_clken ticks int_n stays low after an irq_pulse (Spectrum-style 32 T-state INT).
IM2_VECTOR, 8'hFF, byte driven on cpu_di during an interrupt-acknowledge cycle.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_clken  in  1  CPU clock-enable tick; asserted at most every second clk
a  in  16  CPU address bus
cpu_dout  in  8  CPU data out
m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU strobes
cpu_di  out  8  data to CPU
wait_n  out  1  CPU wait request
int_n  out  1  CPU maskable interrupt
irq_pulse  in  1  one-clk interrupt request
inta_seen  out  1  one-clk pulse on interrupt acknowledge
mem_req, mem_we  out  1 each  memory request and write flag
mem_addr  out  16  latched address
mem_wdata  out  8  latched write data
mem_rdata  in  8  memory read data, valid with mem_ack
mem_ack  in  1  one-clk completion
io_req, io_we  out  1 each  I/O request and write flag
io_addr  out  16  latched port address
io_wdata  out  8  latched write data
io_rdata  in  8  I/O read data, valid with io_ack
io_ack  in  1  one-clk completion

Behaviour:
- Reset: state IDLE; wait_n=1, int_n=1, cpu_di=8'hFF, inta_seen=0, mem_req=io_req=0, mem_we=io_we=0, INT counter=0. Reset during a transaction abandons it at once; mem_req and io_req drop on the next clk. The back end must tolerate an abandoned request.
- Strobes are sampled every clk. All outputs are registered.
- IDLE transitions, in priority order:
  - INTA: !m1_n && !iorq_n. Load cpu_di=IM2_VECTOR, pulse inta_seen, clear int_n, go to HOLD.
  - Memory: !mreq_n && rfsh_n. Go to MEM_DIR.
  - I/O: !iorq_n && m1_n && (!rd_n || !wr_n). Latch io_addr=a, io_we=!wr_n, io_wdata=cpu_dout. Set io_req=1, go to IO_WAIT.
  - Refresh cycles (!rfsh_n) never start a transaction.
- MEM_DIR: wait_n=0. Stay until rd_n or wr_n goes low. Then latch mem_addr=a, mem_we=!wr_n, mem_wdata=cpu_dout, set mem_req=1, go to MEM_WAIT. If mreq_n rises first (aborted cycle), go to IDLE.
- MEM_WAIT / IO_WAIT: wait_n=0. The request stays high and its address/data stay stable until ack.
  - On ack: drop req. For reads, cpu_di=rdata. Go to HOLD.
  - Ack may arrive in the first clk req is high.
- HOLD: wait_n=1 and cpu_di holds. Return to IDLE when mreq_n && iorq_n are both high.
- wait_n latency: low on the clk edge after the strobe is detected. This guarantees it is low before the next cpu_clken edge.
- Interrupt generation:
  - irq_pulse: int_n=0, counter=INT_LEN-1.
  - While int_n=0, counter decrements on each cpu_clken. When the counter is 0 and cpu_clken=1, int_n returns to 1.
  - irq_pulse while already active restarts the counter.
  - INTA detection forces int_n=1.
  - irq_pulse in the same clk as INTA detection wins: int_n=0, counter reloaded, inta_seen still pulses.
- The counter is wide enough for INT_LEN and never wraps below 0.

Test Plan:
- Memory read a=16'h4000: mreq_n, rd_n low; mem_ack 3 clk after mem_req with mem_rdata=8'hA5 -> mem_req 1 until ack, mem_we=0, wait_n low from detection+1 until ack, cpu_di=8'hA5, wait_n=1 after ack.
- Memory write a=16'h8001, cpu_dout=8'h3C, wr_n late by 2 clk -> wait_n low during MEM_DIR; mem_req rises only after wr_n low; mem_we=1, mem_wdata=8'h3C, mem_addr=16'h8001.
- I/O read port 16'hFEFE, io_ack immediately with io_rdata=8'h1F -> single-clk io_req, cpu_di=8'h1F, no mem_req.
- irq_pulse, INT_LEN=32, cpu_clken every 4 clk, no INTA -> int_n low exactly 32 cpu_clken ticks. Repeat with INTA after 5 ticks -> int_n=1 next clk, inta_seen one pulse, cpu_di=8'hFF.
- Refresh cycle (mreq_n=0, rfsh_n=0) -> no mem_req, wait_n stays 1.
- reset asserted in MEM_WAIT -> next clk mem_req=0, wait_n=1, int_n=1, cpu_di=8'hFF; a new cycle after reset completes normally.

Source files
------------

// File: rtl/z80_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_responder
// Purpose  : Bus-side responder for a Z80 core. Decodes the CPU strobes and
//            turns memory and I/O cycles into single request/ack transactions
//            on separate back-end ports. The CPU is stretched with wait_n until
//            the back end acknowledges, and read data is returned on cpu_di.
//            Also generates the maskable INT line (fixed length in CPU ticks)
//            and answers interrupt-acknowledge cycles with an IM2 vector.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            cpu_clken             - CPU T-state tick (at most every 2nd clk)
//            a, cpu_dout           - CPU address / write data
//            m1_n .. rfsh_n        - CPU bus strobes (active low)
//            cpu_di, wait_n, int_n - data, wait and interrupt to the CPU
//            irq_pulse, inta_seen  - interrupt request in / acknowledge pulse
//            mem_*                 - memory back-end request/ack port
//            io_*                  - I/O back-end request/ack port
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_responder #(
    parameter int          INT_LEN    = 32,
    parameter logic [7:0]  IM2_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_clken,
    input  logic [15:0] a,
    input  logic [7:0]  cpu_dout,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    output logic        int_n,
    input  logic        irq_pulse,
    output logic        inta_seen,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        io_req,
    output logic        io_we,
    output logic [15:0] io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack
);

    // Counter holds INT_LEN-1 down to 0; sized so INT_LEN itself also fits.
    localparam int c_CNT_W = (INT_LEN > 1) ? $clog2(INT_LEN + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(INT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_DIR  = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_IO_WAIT  = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_int_cnt;
    logic [c_CNT_W-1:0]  w_int_cnt_nxt;
    logic                w_int_n_nxt;
    logic                w_inta_det;
    logic                w_wait_n_nxt;
    logic [7:0]          w_cpu_di_nxt;
    logic                w_mem_req_nxt;
    logic                w_mem_we_nxt;
    logic [15:0]         w_mem_addr_nxt;
    logic [7:0]          w_mem_wdata_nxt;
    logic                w_io_req_nxt;
    logic                w_io_we_nxt;
    logic [15:0]         w_io_addr_nxt;
    logic [7:0]          w_io_wdata_nxt;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_inta_det      = 1'b0;
        w_cpu_di_nxt    = cpu_di;
        w_mem_req_nxt   = mem_req;
        w_mem_we_nxt    = mem_we;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_io_req_nxt    = io_req;
        w_io_we_nxt     = io_we;
        w_io_addr_nxt   = io_addr;
        w_io_wdata_nxt  = io_wdata;

        case (r_state)
            S_IDLE: begin
                if (!m1_n && !iorq_n) begin
                    w_inta_det   = 1'b1;
                    w_cpu_di_nxt = IM2_VECTOR;
                    w_state_nxt  = S_HOLD;
                end else if (!mreq_n && rfsh_n) begin
                    // Direction is not known yet on a Z80 memory cycle.
                    w_state_nxt = S_MEM_DIR;
                end else if (!iorq_n && m1_n && (!rd_n || !wr_n)) begin
                    w_io_addr_nxt  = a;
                    w_io_we_nxt    = !wr_n;
                    w_io_wdata_nxt = cpu_dout;
                    w_io_req_nxt   = 1'b1;
                    w_state_nxt    = S_IO_WAIT;
                end
            end
            S_MEM_DIR: begin
                if (mreq_n) begin
                    w_state_nxt = S_IDLE;
                end else if (!rd_n || !wr_n) begin
                    w_mem_addr_nxt  = a;
                    w_mem_we_nxt    = !wr_n;
                    w_mem_wdata_nxt = cpu_dout;
                    w_mem_req_nxt   = 1'b1;
                    w_state_nxt     = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (!mem_we) begin
                        w_cpu_di_nxt = mem_rdata;
                    end
                    w_state_nxt = S_HOLD;
                end
            end
            S_IO_WAIT: begin
                if (io_ack) begin
                    w_io_req_nxt = 1'b0;
                    if (!io_we) begin
                        w_cpu_di_nxt = io_rdata;
                    end
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (mreq_n && iorq_n) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Wait is asserted in every state that is still waiting on the back
        // end, so it goes low one clk after detection and well before the
        // next CPU tick samples it.
        w_wait_n_nxt = !((w_state_nxt == S_MEM_DIR)  ||
                         (w_state_nxt == S_MEM_WAIT) ||
                         (w_state_nxt == S_IO_WAIT));
    end

    // ------------------------------------------------------------------
    // Interrupt line: a new request beats acknowledge, acknowledge beats
    // the normal countdown.
    // ------------------------------------------------------------------
    always_comb begin
        w_int_n_nxt   = int_n;
        w_int_cnt_nxt = r_int_cnt;
        if (irq_pulse) begin
            w_int_n_nxt   = 1'b0;
            w_int_cnt_nxt = c_RELOAD;
        end else if (w_inta_det) begin
            w_int_n_nxt   = 1'b1;
            w_int_cnt_nxt = '0;
        end else if (!int_n && cpu_clken) begin
            if (r_int_cnt == '0) begin
                w_int_n_nxt = 1'b1;
            end else begin
                w_int_cnt_nxt = r_int_cnt - c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_int_cnt <= '0;
            int_n     <= 1'b1;
            wait_n    <= 1'b1;
            cpu_di    <= 8'hFF;
            inta_seen <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_int_cnt <= w_int_cnt_nxt;
            int_n     <= w_int_n_nxt;
            wait_n    <= w_wait_n_nxt;
            cpu_di    <= w_cpu_di_nxt;
            inta_seen <= w_inta_det;
            mem_req   <= w_mem_req_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            io_req    <= w_io_req_nxt;
            io_we     <= w_io_we_nxt;
            io_addr   <= w_io_addr_nxt;
            io_wdata  <= w_io_wdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_bus_responder
// Purpose  : Self-checking bench for z80_bus_responder. Directed bus cycles
//            followed by randomized memory/I/O transactions, with the INT
//            line, acknowledge pulse and cpu_di tracked by a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_bus_responder;

    localparam int         c_INT_LEN = 32;
    localparam logic [7:0] c_IM2     = 8'hFF;

    logic        clk;
    logic        reset;
    logic        cpu_clken;
    logic [15:0] a;
    logic [7:0]  cpu_dout;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [7:0]  cpu_di;
    logic        wait_n;
    logic        int_n;
    logic        irq_pulse;
    logic        inta_seen;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        io_req, io_we;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        io_ack;

    z80_bus_responder #(
        .INT_LEN    (c_INT_LEN),
        .IM2_VECTOR (c_IM2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_clken (cpu_clken),
        .a         (a),
        .cpu_dout  (cpu_dout),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .rfsh_n    (rfsh_n),
        .cpu_di    (cpu_di),
        .wait_n    (wait_n),
        .int_n     (int_n),
        .irq_pulse (irq_pulse),
        .inta_seen (inta_seen),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         ticks_left = 0;   // CPU ticks the INT pulse still has to last
    int         tick_count = 0;   // total cpu_clken ticks applied to the DUT
    int         gap_cnt    = 0;
    logic [7:0] exp_di     = 8'hFF;
    bit         inta_exp   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clk: choose cpu_clken for this edge, then update the model
    // and check INT / acknowledge / cpu_di after the edge.
    task automatic cyc();
        bit irq_s, inta_s, rst_s, en_s;
        if (gap_cnt == 0) begin
            cpu_clken = 1'b1;
            gap_cnt   = $urandom_range(1, 3);
        end else begin
            cpu_clken = 1'b0;
            gap_cnt--;
        end
        irq_s  = irq_pulse;
        inta_s = inta_exp;
        rst_s  = reset;
        en_s   = cpu_clken;
        @(posedge clk);
        #1;
        if (en_s) tick_count++;
        if (rst_s) begin
            ticks_left = 0;
            exp_di     = 8'hFF;
        end else if (irq_s) begin
            ticks_left = c_INT_LEN;
        end else if (inta_s) begin
            ticks_left = 0;
        end else if (en_s && ticks_left > 0) begin
            ticks_left--;
        end
        chk("int_n", int_n, (ticks_left == 0) ? 1 : 0);
        chk("inta_seen", inta_seen, (inta_s && !rst_s) ? 1 : 0);
        chk("cpu_di", cpu_di, exp_di);
        inta_exp = 1'b0;
    endtask

    task automatic pulse_irq();
        irq_pulse = 1'b1;
        cyc();
        irq_pulse = 1'b0;
    endtask

    task automatic release_bus();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1;   rfsh_n = 1'b1;
    endtask

    task automatic mem_cycle(input logic [15:0] addr, input bit wr, input logic [7:0] wdata,
                             input int dly, input int ack_dly, input logic [7:0] rdata);
        a        = addr;
        cpu_dout = wdata;
        mreq_n   = 1'b0;
        if (dly == 0) begin
            if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        end
        cyc();
        chk("mem_dir_wait_n", wait_n, 0);
        chk("mem_dir_req", mem_req, 0);
        for (int i = 0; i < dly; i++) begin
            cyc();
            chk("mem_dir_hold_wait_n", wait_n, 0);
            chk("mem_dir_hold_req", mem_req, 0);
        end
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        cyc();
        chk("mem_req_rise", mem_req, 1);
        chk("mem_we", mem_we, wr ? 1 : 0);
        chk("mem_addr", mem_addr, addr);
        chk("mem_wdata", mem_wdata, wdata);
        chk("mem_wait_n", wait_n, 0);
        chk("mem_no_io_req", io_req, 0);
        for (int i = 0; i < ack_dly; i++) begin
            cyc();
            chk("mem_req_held", mem_req, 1);
            chk("mem_wait_held", wait_n, 0);
            chk("mem_addr_stable", mem_addr, addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        if (!wr) exp_di = rdata;
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        chk("mem_req_drop", mem_req, 0);
        chk("mem_ack_wait_n", wait_n, 1);
        cyc();
        chk("mem_hold_wait_n", wait_n, 1);
        chk("mem_hold_req", mem_req, 0);
        release_bus();
        cyc();
        chk("mem_idle_wait_n", wait_n, 1);
    endtask

    task automatic io_cycle(input logic [15:0] port, input bit wr, input logic [7:0] wdata,
                            input int ack_dly, input logic [7:0] rdata);
        a        = port;
        cpu_dout = wdata;
        iorq_n   = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        cyc();
        chk("io_req_rise", io_req, 1);
        chk("io_we", io_we, wr ? 1 : 0);
        chk("io_addr", io_addr, port);
        chk("io_wdata", io_wdata, wdata);
        chk("io_wait_n", wait_n, 0);
        chk("io_no_mem_req", mem_req, 0);
        for (int i = 0; i < ack_dly; i++) begin
            cyc();
            chk("io_req_held", io_req, 1);
            chk("io_wait_held", wait_n, 0);
        end
        io_ack   = 1'b1;
        io_rdata = rdata;
        if (!wr) exp_di = rdata;
        cyc();
        io_ack   = 1'b0;
        io_rdata = 8'($urandom);
        chk("io_req_drop", io_req, 0);
        chk("io_ack_wait_n", wait_n, 1);
        chk("io_ack_no_mem_req", mem_req, 0);
        release_bus();
        cyc();
        chk("io_idle_wait_n", wait_n, 1);
    endtask

    task automatic inta_cycle();
        m1_n     = 1'b0;
        iorq_n   = 1'b0;
        inta_exp = 1'b1;
        exp_di   = c_IM2;
        cyc();
        chk("inta_wait_n", wait_n, 1);
        cyc();
        release_bus();
        cyc();
    endtask

    // Run until int_n rises; returns the number of CPU ticks it stayed low.
    task automatic measure_int(output int ticks);
        int t0 = tick_count;
        int guard = 0;
        while (int_n === 1'b0 && guard < 400) begin
            cyc();
            guard++;
        end
        ticks = tick_count - t0;
    endtask

    initial begin
        int n;
        reset = 1'b1; cpu_clken = 1'b0; a = '0; cpu_dout = '0;
        irq_pulse = 1'b0; mem_rdata = '0; mem_ack = 1'b0; io_rdata = '0; io_ack = 1'b0;
        release_bus();
        repeat (3) cyc();
        chk("rst_wait_n", wait_n, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_io_req", io_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_io_we", io_we, 0);
        reset = 1'b0;
        cyc();

        // Directed bus cycles
        mem_cycle(16'h4000, 1'b0, 8'h00, 0, 3, 8'hA5);
        mem_cycle(16'h8001, 1'b1, 8'h3C, 2, 1, 8'h77);
        io_cycle(16'hFEFE, 1'b0, 8'h00, 0, 8'h1F);

        // Refresh must not start a transaction
        mreq_n = 1'b0; rfsh_n = 1'b0; a = 16'h0042;
        repeat (3) begin
            cyc();
            chk("rfsh_mem_req", mem_req, 0);
            chk("rfsh_wait_n", wait_n, 1);
        end
        release_bus();
        cyc();

        // Full-length INT pulse
        pulse_irq();
        measure_int(n);
        chk("int_len_ticks", n, c_INT_LEN);

        // INT cut short by acknowledge after 5 ticks
        pulse_irq();
        begin
            int t0 = tick_count;
            int guard = 0;
            while (tick_count - t0 < 5 && guard < 100) begin
                cyc();
                guard++;
            end
        end
        inta_cycle();

        // Request arriving with acknowledge wins, then a restart mid-pulse
        m1_n = 1'b0; iorq_n = 1'b0; inta_exp = 1'b1; exp_di = c_IM2; irq_pulse = 1'b1;
        cyc();
        irq_pulse = 1'b0;
        cyc();
        release_bus();
        repeat (20) cyc();
        pulse_irq();
        measure_int(n);
        chk("int_restart_ticks", n, c_INT_LEN);

        // Reset while in MEM_WAIT with INT active and cpu_di not at FF
        io_cycle(16'h00FE, 1'b0, 8'h00, 1, 8'h5A);
        pulse_irq();
        a = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_mem_req", mem_req, 1);
        reset = 1'b1;
        release_bus();
        cyc();
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_wait_n", wait_n, 1);
        reset = 1'b0;
        cyc();
        mem_cycle(16'h2468, 1'b0, 8'h00, 1, 0, 8'hC3);

        // Randomized transactions
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 0)
                mem_cycle(16'($urandom), 1'($urandom), 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
            else
                io_cycle(16'($urandom), 1'($urandom), 8'($urandom),
                         $urandom_range(0, 3), 8'($urandom));
            if ($urandom_range(0, 3) == 0) pulse_irq();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
